sram_lsu_master: RTL and testbench

Requester-side load/store front end that drives the 1rw port of the banked 4096x32 SRAM wrapper on behalf of the RV32I core. It accepts one byte-addressed load or store request at a time on a valid/ready interface. It generates the active-low chip select, write enable, byte write mask, word address and lane-replicated write data for the SRAM. For loads, it waits the SRAM read latency, captures dout, extracts the addressed byte or halfword, and returns it sign- or zero-extended on a one-cycle response pulse.

---
 rtl/sram_lsu_master_if.sv | 46 ++++
 rtl/sram_lsu_master.sv | 216 +++++++++++++++++++++
 tb/tb_sram_lsu_master.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_lsu_master_if.sv
// Request/response and SRAM 1rw port bundle for the LSU front end.
// master: the LSU side (accepts requests, drives responses and the SRAM pins).
// slave : the core/SRAM side (drives requests and mem_dout, observes the rest).
interface sram_lsu_master_if #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_WMASKS = 4
);
    // Core request channel
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_we;
    logic [1:0]              req_size;
    logic                    req_unsigned;
    logic [ADDR_WIDTH+1:0]   req_addr;
    logic [DATA_WIDTH-1:0]   req_wdata;

    // Core response channel (no backpressure)
    logic                    rsp_valid;
    logic [DATA_WIDTH-1:0]   rsp_rdata;
    logic                    rsp_err;

    // SRAM 1rw port
    logic                    mem_csb;
    logic                    mem_web;
    logic [NUM_WMASKS-1:0]   mem_wmask;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_din;
    logic [DATA_WIDTH-1:0]   mem_dout;

    modport master (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  mem_dout,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        output mem_csb, mem_web, mem_wmask, mem_addr, mem_din
    );

    modport slave (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output mem_dout,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        input  mem_csb, mem_web, mem_wmask, mem_addr, mem_din
    );
endinterface

// File: rtl/sram_lsu_master.sv
// Load/store front end driving the 1rw port of a 4096x32 SRAM.
// Accepts one byte-addressed load/store at a time, generates csb/web/wmask/
// word address/lane-replicated write data, waits RD_LATENCY edges for loads,
// extracts and extends the addressed lane, and returns a one-cycle response.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : sram_lsu_master_if.master (request, response, SRAM pins)
module sram_lsu_master #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_WMASKS = 4,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    sram_lsu_master_if.master  bus
);

    localparam int unsigned CNT_W = 3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // State, wait counter and latched request attributes
    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  lat_we_q, lat_we_d;
    logic [1:0]            lat_size_q, lat_size_d;
    logic [1:0]            lat_off_q, lat_off_d;
    logic                  lat_uns_q, lat_uns_d;

    // Registered outputs
    logic                  ready_q, ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  csb_q, csb_d;
    logic                  web_q, web_d;
    logic [NUM_WMASKS-1:0] wmask_q, wmask_d;
    logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;

    // Request decode on the live inputs (used only at the handshake)
    logic                  misaligned_c;
    logic [NUM_WMASKS-1:0] st_mask_c;
    logic [DATA_WIDTH-1:0] st_data_c;

    // Pick the addressed lane out of the read word and extend it
    function automatic logic [31:0] extract_lane(
        input logic [31:0] d,
        input logic [1:0]  size,
        input logic [1:0]  off,
        input logic        uns
    );
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        shifted = d >> {off, 3'b000};
        b       = shifted[7:0];
        h       = off[1] ? d[31:16] : d[15:0];
        case (size)
            SZ_BYTE: extract_lane = {{24{~uns & b[7]}}, b};
            SZ_HALF: extract_lane = {{16{~uns & h[15]}}, h};
            default: extract_lane = d;
        endcase
    endfunction

    // Misalignment and store lane replication
    always_comb begin
        misaligned_c = 1'b0;
        st_mask_c    = NUM_WMASKS'(4'hF);
        st_data_c    = DATA_WIDTH'(bus.req_wdata);
        case (bus.req_size)
            SZ_BYTE: begin
                st_mask_c = NUM_WMASKS'(4'b0001 << bus.req_addr[1:0]);
                st_data_c = DATA_WIDTH'({4{bus.req_wdata[7:0]}});
            end
            SZ_HALF: begin
                misaligned_c = bus.req_addr[0];
                st_mask_c    = NUM_WMASKS'(4'b0011 << bus.req_addr[1:0]);
                st_data_c    = DATA_WIDTH'({2{bus.req_wdata[15:0]}});
            end
            SZ_WORD: begin
                misaligned_c = (bus.req_addr[1:0] != 2'b00);
            end
            default: begin
                misaligned_c = 1'b1;
            end
        endcase
    end

    // Next state and next registered outputs
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lat_we_d    = lat_we_q;
        lat_size_d  = lat_size_q;
        lat_off_d   = lat_off_q;
        lat_uns_d   = lat_uns_q;
        ready_d     = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        csb_d       = 1'b1;
        web_d       = 1'b1;
        wmask_d     = '0;
        maddr_d     = maddr_q;
        din_d       = din_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    lat_we_d   = bus.req_we;
                    lat_size_d = bus.req_size;
                    lat_off_d  = bus.req_addr[1:0];
                    lat_uns_d  = bus.req_unsigned;
                    if (misaligned_c) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        // ISSUE-cycle pin values are registered straight off the request
                        state_d = ST_ISSUE;
                        csb_d   = 1'b0;
                        web_d   = ~bus.req_we;
                        maddr_d = bus.req_addr[ADDR_WIDTH+1:2];
                        if (bus.req_we) begin
                            wmask_d = st_mask_c;
                            din_d   = st_data_c;
                        end
                    end
                end else begin
                    ready_d = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (lat_we_q) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(RD_LATENCY);
                end
            end
            ST_WAIT: begin
                // Capture on the RD_LATENCY-th edge after the issue edge
                if (cnt_q == CNT_W'(1)) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = DATA_WIDTH'(extract_lane(32'(bus.mem_dout), lat_size_q,
                                                           lat_off_q, lat_uns_q));
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            lat_we_q    <= 1'b0;
            lat_size_q  <= 2'b00;
            lat_off_q   <= 2'b00;
            lat_uns_q   <= 1'b0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            csb_q       <= 1'b1;
            web_q       <= 1'b1;
            wmask_q     <= '0;
            maddr_q     <= '0;
            din_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lat_we_q    <= lat_we_d;
            lat_size_q  <= lat_size_d;
            lat_off_q   <= lat_off_d;
            lat_uns_q   <= lat_uns_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            csb_q       <= csb_d;
            web_q       <= web_d;
            wmask_q     <= wmask_d;
            maddr_q     <= maddr_d;
            din_q       <= din_d;
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.mem_csb   = csb_q;
    assign bus.mem_web   = web_q;
    assign bus.mem_wmask = wmask_q;
    assign bus.mem_addr  = maddr_q;
    assign bus.mem_din   = din_q;

endmodule

// File: tb/tb_sram_lsu_master.sv
// Directed bench for sram_lsu_master: two instances (RD_LATENCY 1 and 3), each
// with a behavioural SRAM whose dout is valid only in the sampling window.
module tb_sram_lsu_master;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    sram_lsu_master_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .NUM_WMASKS(4)) bif1 ();
    sram_lsu_master_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .NUM_WMASKS(4)) bif3 ();

    sram_lsu_master #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .NUM_WMASKS(4), .RD_LATENCY(1))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(bif1.master));
    sram_lsu_master #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .NUM_WMASKS(4), .RD_LATENCY(3))
        dut3 (.clk(clk), .rst_n(rst_n), .bus(bif3.master));

    // Shared request stimulus, valid steered by sel (0 -> dut1, 1 -> dut3)
    logic        sel = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_we = 1'b0;
    logic [1:0]  s_size = 2'd0;
    logic        s_uns = 1'b0;
    logic [13:0] s_addr = '0;
    logic [31:0] s_wdata = '0;

    assign bif1.req_valid = s_valid & ~sel;
    assign bif3.req_valid = s_valid & sel;
    assign bif1.req_we = s_we;          assign bif3.req_we = s_we;
    assign bif1.req_size = s_size;      assign bif3.req_size = s_size;
    assign bif1.req_unsigned = s_uns;   assign bif3.req_unsigned = s_uns;
    assign bif1.req_addr = s_addr;      assign bif3.req_addr = s_addr;
    assign bif1.req_wdata = s_wdata;    assign bif3.req_wdata = s_wdata;

    // Selected-instance observation
    logic        o_ready, o_rsp_valid, o_err, o_csb, o_web;
    logic [31:0] o_rdata, o_din;
    logic [3:0]  o_wmask;
    logic [11:0] o_maddr;
    assign o_ready     = sel ? bif3.req_ready : bif1.req_ready;
    assign o_rsp_valid = sel ? bif3.rsp_valid : bif1.rsp_valid;
    assign o_rdata     = sel ? bif3.rsp_rdata : bif1.rsp_rdata;
    assign o_err       = sel ? bif3.rsp_err   : bif1.rsp_err;
    assign o_csb       = sel ? bif3.mem_csb   : bif1.mem_csb;
    assign o_web       = sel ? bif3.mem_web   : bif1.mem_web;
    assign o_wmask     = sel ? bif3.mem_wmask : bif1.mem_wmask;
    assign o_maddr     = sel ? bif3.mem_addr  : bif1.mem_addr;
    assign o_din       = sel ? bif3.mem_din   : bif1.mem_din;

    // Behavioural SRAMs: read data valid only for the edge issue+RD_LATENCY
    logic [31:0] mem1 [4096];
    logic [31:0] mem3 [4096];
    logic [31:0] rd_word1 = '0, rd_word3 = '0;
    logic [2:0]  rd_age1 = 3'd7, rd_age3 = 3'd7;

    always @(posedge clk) begin
        if (!bif1.mem_csb && !bif1.mem_web) begin
            for (int i = 0; i < 4; i++)
                if (bif1.mem_wmask[i]) mem1[bif1.mem_addr][8*i +: 8] <= bif1.mem_din[8*i +: 8];
        end else if (!bif1.mem_csb) begin
            rd_word1 <= mem1[bif1.mem_addr];
            rd_age1  <= 3'd0;
        end else if (rd_age1 != 3'd7) begin
            rd_age1 <= rd_age1 + 3'd1;
        end
    end

    always @(posedge clk) begin
        if (!bif3.mem_csb && !bif3.mem_web) begin
            for (int j = 0; j < 4; j++)
                if (bif3.mem_wmask[j]) mem3[bif3.mem_addr][8*j +: 8] <= bif3.mem_din[8*j +: 8];
        end else if (!bif3.mem_csb) begin
            rd_word3 <= mem3[bif3.mem_addr];
            rd_age3  <= 3'd0;
        end else if (rd_age3 != 3'd7) begin
            rd_age3 <= rd_age3 + 3'd1;
        end
    end

    assign bif1.mem_dout = (rd_age1 == 3'd0) ? rd_word1 : 32'h5A5A5A5A;
    assign bif3.mem_dout = (rd_age3 == 3'd2) ? rd_word3 : 32'h5A5A5A5A;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard of expected responses, popped by the response monitor
    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb[$];

    logic after_rsp = 1'b0;
    always @(negedge clk) begin
        if (o_rsp_valid) begin
            chk("rsp_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_rdata", o_rdata, e.rdata);
                chk("rsp_err", 32'(o_err), 32'(e.err));
            end
            after_rsp = 1'b1;
        end else if (after_rsp) begin
            chk("rdata_cleared", o_rdata, 32'd0);
            chk("err_cleared", 32'(o_err), 32'd0);
            after_rsp = 1'b0;
        end
    end

    // ISSUE-cycle pin snapshot from the last request
    logic [3:0]  iss_wmask;
    logic [31:0] iss_din;
    logic [11:0] iss_addr;
    logic        iss_web;

    // One request: handshake, track latency/ready/csb until the response
    task automatic do_req(input logic d, input logic we, input logic [1:0] size,
                          input logic uns, input logic [13:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
        int  n;
        int  csb_lo;
        bit  got;
        @(negedge clk);
        sel = d;
        #1;
        chk("ready_idle", 32'(o_ready), 32'd1);
        s_we = we; s_size = size; s_uns = uns; s_addr = addr; s_wdata = wdata;
        s_valid = 1'b1;
        sb.push_back('{rdata: exp_rd, err: exp_err});
        @(negedge clk);
        s_valid = 1'b0;
        s_we = 1'($urandom); s_size = 2'($urandom); s_uns = 1'($urandom);
        s_addr = 14'($urandom); s_wdata = $urandom;
        n = 1; csb_lo = 0; got = 0;
        iss_wmask = 4'hx; iss_din = 'x; iss_addr = 'x; iss_web = 1'bx;
        while (n <= 20 && !got) begin
            if (!o_csb) begin
                csb_lo++;
                iss_wmask = o_wmask; iss_din = o_din; iss_addr = o_maddr; iss_web = o_web;
            end
            if (o_rsp_valid) begin
                got = 1;
            end else begin
                chk("ready_busy", 32'(o_ready), 32'd0);
                @(negedge clk);
                n++;
            end
        end
        chk("latency", got ? n : -1, exp_lat);
        chk("csb_low_cycles", csb_lo, exp_err ? 0 : 1);
        if (!got && sb.size() != 0) void'(sb.pop_back());
    endtask

    initial begin
        // Reset values on both instances
        repeat (2) @(negedge clk);
        chk("rst_ready1", 32'(bif1.req_ready), 32'd1);
        chk("rst_rsp_valid1", 32'(bif1.rsp_valid), 32'd0);
        chk("rst_rdata1", bif1.rsp_rdata, 32'd0);
        chk("rst_err1", 32'(bif1.rsp_err), 32'd0);
        chk("rst_csb1", 32'(bif1.mem_csb), 32'd1);
        chk("rst_web1", 32'(bif1.mem_web), 32'd1);
        chk("rst_wmask1", 32'(bif1.mem_wmask), 32'd0);
        chk("rst_addr1", 32'(bif1.mem_addr), 32'd0);
        chk("rst_din1", bif1.mem_din, 32'd0);
        chk("rst_ready3", 32'(bif3.req_ready), 32'd1);
        chk("rst_csb3", 32'(bif3.mem_csb), 32'd1);
        rst_n = 1'b1;

        // Word store then word load (RD_LATENCY=1)
        do_req(0, 1, 2'd2, 0, 14'h0010, 32'hDEADBEEF, 32'd0, 0, 2);
        chk("sw_addr", 32'(iss_addr), 32'd4);
        chk("sw_wmask", 32'(iss_wmask), 32'hF);
        chk("sw_web", 32'(iss_web), 32'd0);
        chk("sw_din", iss_din, 32'hDEADBEEF);
        do_req(0, 0, 2'd2, 0, 14'h0010, 32'd0, 32'hDEADBEEF, 0, 3);
        chk("lw_web", 32'(iss_web), 32'd1);
        chk("lw_wmask", 32'(iss_wmask), 32'd0);
        chk("lw_addr", 32'(iss_addr), 32'd4);

        // Byte and half store lanes
        do_req(0, 1, 2'd0, 0, 14'h0013, 32'h000000A5, 32'd0, 0, 2);
        chk("sb_wmask", 32'(iss_wmask), 32'h8);
        chk("sb_din", iss_din, 32'hA5A5A5A5);
        chk("sb_addr", 32'(iss_addr), 32'd4);
        do_req(0, 0, 2'd2, 0, 14'h0010, 32'd0, 32'hA5ADBEEF, 0, 3);
        do_req(0, 1, 2'd1, 0, 14'h0012, 32'hFFFF1234, 32'd0, 0, 2);
        chk("sh_wmask", 32'(iss_wmask), 32'hC);
        chk("sh_din", iss_din, 32'h12341234);
        do_req(0, 0, 2'd1, 1, 14'h0012, 32'd0, 32'h00001234, 0, 3);

        // Load extension on 0x80F27F81
        do_req(0, 1, 2'd2, 0, 14'h0010, 32'h80F27F81, 32'd0, 0, 2);
        do_req(0, 0, 2'd0, 0, 14'h0010, 32'd0, 32'hFFFFFF81, 0, 3);
        do_req(0, 0, 2'd0, 1, 14'h0010, 32'd0, 32'h00000081, 0, 3);
        do_req(0, 0, 2'd1, 0, 14'h0012, 32'd0, 32'hFFFF80F2, 0, 3);
        do_req(0, 0, 2'd1, 1, 14'h0012, 32'd0, 32'h000080F2, 0, 3);
        do_req(0, 0, 2'd0, 0, 14'h0011, 32'd0, 32'h0000007F, 0, 3);
        do_req(0, 0, 2'd0, 0, 14'h0013, 32'd0, 32'hFFFFFF80, 0, 3);
        do_req(0, 0, 2'd1, 0, 14'h0010, 32'd0, 32'h00007F81, 0, 3);

        // Misaligned and illegal size: error after 1 cycle, no SRAM access
        do_req(0, 0, 2'd2, 0, 14'h0006, 32'd0, 32'd0, 1, 1);
        do_req(0, 0, 2'd1, 0, 14'h0001, 32'd0, 32'd0, 1, 1);
        do_req(0, 0, 2'd3, 0, 14'h0010, 32'd0, 32'd0, 1, 1);
        do_req(0, 1, 2'd1, 0, 14'h0013, 32'h0000FFFF, 32'd0, 1, 1);
        do_req(0, 1, 2'd2, 0, 14'h0012, 32'h00000000, 32'd0, 1, 1);
        do_req(0, 0, 2'd2, 0, 14'h0010, 32'd0, 32'h80F27F81, 0, 3);

        // RD_LATENCY=3 instance
        do_req(1, 1, 2'd2, 0, 14'h0020, 32'h12345678, 32'd0, 0, 2);
        chk("l3_sw_addr", 32'(iss_addr), 32'd8);
        do_req(1, 0, 2'd2, 0, 14'h0020, 32'd0, 32'h12345678, 0, 5);
        do_req(1, 0, 2'd0, 0, 14'h0023, 32'd0, 32'h00000012, 0, 5);
        do_req(1, 1, 2'd2, 0, 14'h0020, 32'hCAFE8000, 32'd0, 0, 2);
        do_req(1, 0, 2'd1, 0, 14'h0020, 32'd0, 32'hFFFF8000, 0, 5);

        // Reset while the latency-3 load sits in WAIT: no response follows
        @(negedge clk);
        sel = 1'b1;
        s_we = 1'b0; s_size = 2'd2; s_uns = 1'b0; s_addr = 14'h0020; s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_csb", 32'(bif3.mem_csb), 32'd1);
        chk("midrst_ready", 32'(bif3.req_ready), 32'd1);
        chk("midrst_rsp_valid", 32'(bif3.rsp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("midrst_no_rsp", 32'(bif3.rsp_valid), 32'd0);
        end
        do_req(1, 0, 2'd2, 0, 14'h0020, 32'd0, 32'hCAFE8000, 0, 5);

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
